mem_march_tester: RTL and testbench
===================================

Name: mem_march_tester

Overview:
- Self-checking SDRAM traffic generator. It sits directly upstream of the SDRAM controller core and drives its request side: address, write data, write strobe.
- Writes a deterministic pattern over a configurable address window. It then reads the window back, compares in-order read returns, and reports pass/fail, error count and first-failure details for the 7-segment/LED debug path.

Parameters:
- ADDR_W, 22, request address width
- DATA_W, 16, data width
- START_ADDR, 0, first word address tested
- NUM_WORDS, 256, words in test window (>=1)
- SEED, 16'hA5C3, pattern key
- MAX_OUT, 4, maximum outstanding reads (1..15)
- TIMEOUT, 1024, idle cycles allowed for a pending read return

Ports:
- clk  in  1  controller clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse/level; begins a run when idle or done
- mem_wait  in  1  controller busy; request not accepted while high
- mem_valid  in  1  read data valid, one word per cycle, in issue order
- mem_rdata  in  DATA_W  read data
- mem_req  out  1  request valid
- mem_we  out  1  1=write, 0=read (meaningful when mem_req=1)
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- busy  out  1  run in progress
- done  out  1  run finished (sticky until next start/reset)
- pass  out  1  done and err_count==0 and no timeout
- err_count  out  16  mismatches, saturating at 16'hFFFF
- first_err_addr  out  ADDR_W  address of first mismatch
- first_err_data  out  DATA_W  data read at first mismatch
- timeout  out  1  sticky; read return watchdog expired
- unexp_valid  out  1  sticky; mem_valid with zero outstanding reads

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0; counters and error capture 0.
- Pattern: pat(a) = a[DATA_W-1:0] ^ SEED. Addresses advance +1 modulo 2^ADDR_W; last address is START_ADDR+NUM_WORDS-1 (wraps).
- Handshake: a request is accepted in a cycle with mem_req=1 and mem_wait=0. While mem_wait=1, mem_req/mem_we/mem_addr/mem_wdata hold stable.
- States:
  - IDLE: start=1 -> WRITE. Clears counters and sticky flags, busy=1, done=0.
  - WRITE: mem_req=1, mem_we=1, mem_wdata=pat(mem_addr). On accept of the last address -> READ, with mem_addr reloaded to START_ADDR.
  - READ: mem_req=1 and mem_we=0 only while outstanding<MAX_OUT. Issue counter advances on accept. After the last read accepted -> DRAIN.
  - DRAIN: mem_req=0; waits until outstanding==0 -> DONE.
  - DONE: busy=0, done=1, pass valid. start=1 -> WRITE (restart).
- Outstanding counter: +1 on read accept, -1 on mem_valid; both in the same cycle leaves it unchanged.
- Compare: an expected-address counter starts at START_ADDR and advances on each valid. A mismatch of mem_rdata against pat(expected) increments err_count (saturating). first_err_* are captured only when err_count was 0.
- mem_valid with outstanding==0: ignored for compare, sets unexp_valid, counter does not underflow.
- Watchdog: counts cycles with outstanding>0 and no mem_valid; reset on each valid.
  - Reaching TIMEOUT: set timeout, add outstanding to err_count (saturating), force outstanding=0, go to DONE.
- start while busy: ignored.
- Reset mid-run: immediate return to IDLE; no further requests; late mem_valid after reset sets unexp_valid only if in a run.
- Latency: first request is presented the cycle after start is sampled in IDLE; done asserts the cycle after the final return.

Optional Feature:
- INVERT_PASS_EN defined: after the first DRAIN empties, a second pass runs (WRITE2/READ2/DRAIN2) with pattern ~pat(a) over the same window, then DONE. Errors accumulate across both passes; first_err captures the earliest overall.
- Undefined: single pass; WRITE2/READ2/DRAIN2 states do not exist.

Test Plan:
- NUM_WORDS=4, SEED=A5C3, ideal memory with 3-cycle read latency and mem_wait=0, start pulse -> writes A5C3,A5C2,A5C1,A5C0 to addr 0..3, four reads, done=1, pass=1, err_count=0.
- Same setup, model corrupts addr 2 return to 0000 -> err_count=1, first_err_addr=2, first_err_data=0000, pass=0.
- mem_wait held high 5 cycles during WRITE addr 1 -> mem_addr=1 and mem_wdata=A5C2 stable all 5 cycles; no skipped or duplicated address.
- MAX_OUT=2, memory latency 10 -> never more than 2 reads outstanding; run completes with pass=1.
- TIMEOUT=16, memory drops last read return -> timeout=1, err_count=1, done=1 about 16 cycles after the last valid.
- rst_n low during READ, then start -> all outputs 0 during reset; fresh run passes; mem_valid pulse in IDLE -> unexp_valid stays 0.

Source files
------------

// File: rtl/mem_march_tester.sv
// March-style SDRAM traffic generator: writes pat(a) over a window, reads it back in order, and
// reports pass/fail. Optional macro INVERT_PASS_EN adds a second pass with the inverted pattern.
module mem_march_tester #(
   parameter int unsigned       ADDR_W     = 22,
   parameter int unsigned       DATA_W     = 16,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter int unsigned       NUM_WORDS  = 256,
   parameter logic [DATA_W-1:0] SEED       = 16'hA5C3,
   parameter int unsigned       MAX_OUT    = 4,
   parameter int unsigned       TIMEOUT    = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mem_wait,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_data,
   output logic              timeout,
   output logic              unexp_valid
);

   localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned OUT_W = 4;
   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRead,
      StDrain,
      StDone
`ifdef INVERT_PASS_EN
      ,
      StWrite2,
      StRead2,
      StDrain2
`endif
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
   logic [OUT_W-1:0]    outstanding_q, outstanding_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [15:0]         err_q, err_d;
   logic [ADDR_W-1:0]   fe_addr_q, fe_addr_d;
   logic [DATA_W-1:0]   fe_data_q, fe_data_d;
   logic                timeout_q, timeout_d;
   logic                unexp_q, unexp_d;

   logic                is_write, is_read, is_drain, inv;
   logic                accept, rd_acc, valid_ok, mismatch, last_word, wd_fire, begin_run;
   logic [16:0]         err_sum;
   logic [DATA_W-1:0]   exp_data;

   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic invert);
      logic [DATA_W-1:0] p;
      p = a[DATA_W-1:0] ^ SEED;
      return invert ? ~p : p;
   endfunction

   always_comb begin
      is_write = 1'b0;
      is_read  = 1'b0;
      is_drain = 1'b0;
      inv      = 1'b0;
      unique case (state_q)
         StWrite:  is_write = 1'b1;
         StRead:   is_read  = 1'b1;
         StDrain:  is_drain = 1'b1;
`ifdef INVERT_PASS_EN
         StWrite2: begin is_write = 1'b1; inv = 1'b1; end
         StRead2:  begin is_read  = 1'b1; inv = 1'b1; end
         StDrain2: begin is_drain = 1'b1; inv = 1'b1; end
`endif
         default:  ;
      endcase
   end

   // Request outputs depend only on registered state, so they hold while mem_wait is high.
   assign mem_req   = is_write | (is_read & (outstanding_q < OUT_W'(MAX_OUT)));
   assign mem_we    = is_write;
   assign mem_addr  = mem_req ? addr_q : '0;
   assign mem_wdata = is_write ? pat(addr_q, inv) : '0;

   assign accept    = mem_req & ~mem_wait;
   assign rd_acc    = accept & is_read;
   assign valid_ok  = mem_valid & (outstanding_q != '0);
   assign exp_data  = pat(exp_addr_q, inv);
   assign mismatch  = valid_ok & (mem_rdata != exp_data);
   assign last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));
   assign err_sum   = {1'b0, err_q} + 17'(outstanding_q);

   assign busy           = (state_q != StIdle) && (state_q != StDone);
   assign done           = (state_q == StDone);
   assign pass           = done && (err_q == '0) && !timeout_q;
   assign err_count      = err_q;
   assign first_err_addr = fe_addr_q;
   assign first_err_data = fe_data_q;
   assign timeout        = timeout_q;
   assign unexp_valid    = unexp_q;
   assign begin_run      = start && ((state_q == StIdle) || (state_q == StDone));

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      exp_addr_d    = exp_addr_q;
      outstanding_d = outstanding_q;
      wd_d          = wd_q;
      err_d         = err_q;
      fe_addr_d     = fe_addr_q;
      fe_data_d     = fe_data_q;
      timeout_d     = timeout_q;
      unexp_d       = unexp_q;
      wd_fire       = 1'b0;

      unique case ({rd_acc, valid_ok})
         2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
         2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
         default: ;
      endcase

      if (valid_ok) begin
         exp_addr_d = exp_addr_q + ADDR_W'(1);
      end
      if (mismatch) begin
         if (err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
         end
         if (err_q == '0) begin
            fe_addr_d = exp_addr_q;
            fe_data_d = mem_rdata;
         end
      end
      if (mem_valid && (outstanding_q == '0) && busy) begin
         unexp_d = 1'b1;
      end

      if ((outstanding_q != '0) && !mem_valid) begin
         if (wd_q == WD_W'(TIMEOUT - 1)) begin
            wd_fire = 1'b1;
         end else begin
            wd_d = wd_q + WD_W'(1);
         end
      end else begin
         wd_d = '0;
      end

      if (accept) begin
         addr_d = addr_q + ADDR_W'(1);
         cnt_d  = cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         StWrite: begin
            if (accept && last_word) begin
               state_d = StRead;
               addr_d  = START_ADDR;
               cnt_d   = '0;
            end
         end
         StRead: begin
            if (accept && last_word) state_d = StDrain;
         end
         StDrain: begin
            if (outstanding_d == '0) begin
`ifdef INVERT_PASS_EN
               state_d    = StWrite2;
               addr_d     = START_ADDR;
               cnt_d      = '0;
               exp_addr_d = START_ADDR;
`else
               state_d = StDone;
`endif
            end
         end
`ifdef INVERT_PASS_EN
         StWrite2: begin
            if (accept && last_word) begin
               state_d = StRead2;
               addr_d  = START_ADDR;
               cnt_d   = '0;
            end
         end
         StRead2: begin
            if (accept && last_word) state_d = StDrain2;
         end
         StDrain2: begin
            if (outstanding_d == '0) state_d = StDone;
         end
`endif
         default: ;
      endcase

      // Lost returns count as errors so a hung controller can never report pass.
      if (wd_fire) begin
         state_d       = StDone;
         outstanding_d = '0;
         wd_d          = '0;
         timeout_d     = 1'b1;
         err_d         = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end

      if (begin_run) begin
         state_d       = StWrite;
         addr_d        = START_ADDR;
         cnt_d         = '0;
         exp_addr_d    = START_ADDR;
         outstanding_d = '0;
         wd_d          = '0;
         err_d         = '0;
         fe_addr_d     = '0;
         fe_data_d     = '0;
         timeout_d     = 1'b0;
         unexp_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         cnt_q         <= '0;
         exp_addr_q    <= '0;
         outstanding_q <= '0;
         wd_q          <= '0;
         err_q         <= '0;
         fe_addr_q     <= '0;
         fe_data_q     <= '0;
         timeout_q     <= 1'b0;
         unexp_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         exp_addr_q    <= exp_addr_d;
         outstanding_q <= outstanding_d;
         wd_q          <= wd_d;
         err_q         <= err_d;
         fe_addr_q     <= fe_addr_d;
         fe_data_q     <= fe_data_d;
         timeout_q     <= timeout_d;
         unexp_q       <= unexp_d;
      end
   end

endmodule

// File: tb/tb_mem_march_tester.sv
// Bench for mem_march_tester: negedge memory model with a request scoreboard, one task per scenario.
module tb_mem_march_tester;

   localparam int ADDR_W = 22;
   localparam int DATA_W = 16;

   logic              clk, rst_n, start, mem_wait, mem_valid;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_req, mem_we, busy, done, pass, timeout, unexp_valid;
   logic [ADDR_W-1:0] mem_addr, first_err_addr;
   logic [DATA_W-1:0] mem_wdata, first_err_data;
   logic [15:0]       err_count;

   mem_march_tester #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_ADDR('0), .NUM_WORDS(4),
      .SEED(16'hA5C3), .MAX_OUT(2), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mem_wait(mem_wait), .mem_valid(mem_valid),
      .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(first_err_addr), .first_err_data(first_err_data), .timeout(timeout),
      .unexp_valid(unexp_valid)
   );

   typedef struct {logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} req_t;
   typedef struct {int due; logic [DATA_W-1:0] data;} ret_t;

   req_t              exp_q[$];
   ret_t              pend[$];
   logic [DATA_W-1:0] mem[4];
   int n_tests = 0, n_fail = 0;
   int cyc = 0, lat = 3, corrupt_addr = -1, drop_addr = -1;
   int tb_out = 0, max_seen = 0, last_valid_cyc = 0, wait_cycles = 0, wait_left = 0;
   bit wait_arm = 0, inject = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] tb_pat(input int a);
      logic [DATA_W-1:0] v;
      v = DATA_W'(a);
      return v ^ 16'hA5C3;
   endfunction

   // Memory model: decides mem_wait/mem_valid for the coming edge and checks each accepted request.
   initial begin
      req_t e;
      ret_t r;
      bit   acc_rd, val;
      mem_wait = 0; mem_valid = 0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         acc_rd = 0; val = 0;
         if (wait_left > 0 || (wait_arm && mem_req && mem_we && mem_addr == 1)) begin
            if (wait_left > 0) wait_left--;
            else begin wait_arm = 0; wait_left = 4; end
            mem_wait = 1; wait_cycles++;
            n_tests++;
            if (!(mem_req && mem_we && mem_addr == 1 && mem_wdata == 16'hA5C2)) begin
               n_fail++;
               $display("FAIL wait_hold: req=%b we=%b addr=%0h wdata=%h, want 1 1 1 a5c2",
                        mem_req, mem_we, mem_addr, mem_wdata);
            end
         end else begin
            mem_wait = 0;
         end
         if (mem_req && !mem_wait) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL extra_req: we=%b addr=%0h, want no request", mem_we, mem_addr);
            end else begin
               e = exp_q.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
                  n_fail++;
                  $display("FAIL req_order: we=%b addr=%0h wdata=%h, want we=%b addr=%0h wdata=%h",
                           mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
               end
            end
            if (mem_we) mem[mem_addr[1:0]] = mem_wdata;
            else begin
               acc_rd = 1;
               if (int'(mem_addr) != drop_addr) begin
                  r.due  = cyc + lat;
                  r.data = (int'(mem_addr) == corrupt_addr) ? '0 : mem[mem_addr[1:0]];
                  pend.push_back(r);
               end
            end
         end
         if (inject) begin
            inject = 0; mem_valid = 1; mem_rdata = 16'h1234;
         end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            mem_valid = 1; mem_rdata = r.data; val = 1; last_valid_cyc = cyc;
         end else begin
            mem_valid = 0; mem_rdata = '0;
         end
         tb_out = tb_out + int'(acc_rd) - int'(val);
         if (tb_out > max_seen) max_seen = tb_out;
      end
   end

   task automatic start_run();
      req_t e;
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         e.we = 1; e.addr = ADDR_W'(i); e.data = tb_pat(i); exp_q.push_back(e);
      end
      for (int i = 0; i < 4; i++) begin
         e.we = 0; e.addr = ADDR_W'(i); e.data = '0; exp_q.push_back(e);
      end
      tb_out = 0; max_seen = 0;
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
   endtask

   task automatic wait_done(output int dcyc);
      int k = 0;
      while (done !== 1'b1 && k < 600) begin @(negedge clk); k++; end
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_wait: done=%b after %0d cycles, want 1", done, k);
      end
      dcyc = cyc;
   endtask

   task automatic test_reset();
      rst_n = 0; start = 0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, busy, done, pass, err_count, first_err_addr,
           first_err_data, timeout, unexp_valid} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b busy=%b done=%b err=%h, want all 0",
                  mem_req, busy, done, err_count);
      end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int dc;
      lat = 3; corrupt_addr = -1; drop_addr = -1;
      start_run();
      n_tests++;
      if (!(mem_req && mem_we && mem_addr == 0 && mem_wdata == 16'hA5C3 && busy)) begin
         n_fail++;
         $display("FAIL first_req: req=%b we=%b addr=%0h wdata=%h busy=%b, want 1 1 0 a5c3 1",
                  mem_req, mem_we, mem_addr, mem_wdata, busy);
      end
      wait_done(dc);
      n_tests++;
      if ({pass, err_count, timeout, unexp_valid, busy} !== {1'b1, 16'h0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_result: pass=%b err=%h to=%b unexp=%b busy=%b, want 1 0 0 0 0",
                  pass, err_count, timeout, unexp_valid, busy);
      end
      n_tests++;
      if (dc - last_valid_cyc != 1) begin
         n_fail++;
         $display("FAIL done_latency: %0d cycles after last return, want 1", dc - last_valid_cyc);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL basic_scoreboard: %0d requests missing, want 0", exp_q.size());
      end
   endtask

   task automatic test_corrupt();
      int dc;
      corrupt_addr = 2;
      start_run();
      wait_done(dc);
      corrupt_addr = -1;
      n_tests++;
      if (err_count !== 16'd1 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL corrupt_err: err=%h pass=%b, want 0001 0", err_count, pass);
      end
      n_tests++;
      if (first_err_addr !== 22'd2 || first_err_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL corrupt_capture: addr=%0h data=%h, want 2 0000",
                  first_err_addr, first_err_data);
      end
   endtask

   task automatic test_wait();
      int dc;
      wait_cycles = 0; wait_arm = 1;
      start_run();
      wait_done(dc);
      n_tests++;
      if (wait_cycles != 5) begin
         n_fail++;
         $display("FAIL wait_len: %0d wait cycles, want 5", wait_cycles);
      end
      n_tests++;
      if (pass !== 1'b1 || err_count !== 16'd0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL wait_result: pass=%b err=%h left=%0d, want 1 0 0",
                  pass, err_count, exp_q.size());
      end
   endtask

   task automatic test_max_out();
      int dc;
      lat = 10;
      start_run();
      wait_done(dc);
      lat = 3;
      n_tests++;
      if (max_seen != 2) begin
         n_fail++;
         $display("FAIL max_out: peak outstanding %0d, want 2", max_seen);
      end
      n_tests++;
      if (pass !== 1'b1 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL max_out_result: pass=%b timeout=%b, want 1 0", pass, timeout);
      end
   endtask

   task automatic test_timeout();
      int dc;
      drop_addr = 3;
      start_run();
      wait_done(dc);
      drop_addr = -1;
      n_tests++;
      if ({timeout, err_count, pass} !== {1'b1, 16'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL timeout_flags: to=%b err=%h pass=%b, want 1 0001 0",
                  timeout, err_count, pass);
      end
      // 16 idle cycles after the last return, done visible the cycle after the watchdog fires
      n_tests++;
      if (dc - last_valid_cyc != 17) begin
         n_fail++;
         $display("FAIL timeout_latency: done %0d cycles after last return, want 17",
                  dc - last_valid_cyc);
      end
   endtask

   task automatic test_unexpected();
      int dc;
      start_run();
      inject = 1;
      wait_done(dc);
      n_tests++;
      if ({unexp_valid, pass, err_count} !== {1'b1, 1'b1, 16'd0}) begin
         n_fail++;
         $display("FAIL unexp_in_run: unexp=%b pass=%b err=%h, want 1 1 0",
                  unexp_valid, pass, err_count);
      end
   endtask

   task automatic test_reset_mid();
      int dc, k = 0;
      lat = 10;
      start_run();
      while (!(mem_req && !mem_we) && k < 100) begin @(negedge clk); k++; end
      @(negedge clk);
      rst_n = 0;
      #1;
      n_tests++;
      if ({mem_req, busy, done, pass, err_count, unexp_valid} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: req=%b busy=%b done=%b, want 0 0 0",
                  mem_req, busy, done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1;
      lat = 3;
      inject = 1;
      repeat (20) @(negedge clk);
      n_tests++;
      if ({unexp_valid, busy, done, mem_req} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_idle: unexp=%b busy=%b done=%b req=%b, want 0 0 0 0",
                  unexp_valid, busy, done, mem_req);
      end
      start_run();
      wait_done(dc);
      n_tests++;
      if (pass !== 1'b1 || unexp_valid !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_rerun: pass=%b unexp=%b left=%0d, want 1 0 0",
                  pass, unexp_valid, exp_q.size());
      end
   endtask

   task automatic test_start_busy();
      int dc;
      start_run();
      start = 1;
      @(negedge clk);
      start = 0;
      wait_done(dc);
      n_tests++;
      if (pass !== 1'b1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL start_busy: pass=%b left=%0d, want 1 0", pass, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corrupt();
      test_wait();
      test_max_out();
      test_timeout();
      test_unexpected();
      test_start_busy();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, want finish");
      $fatal(1, "global timeout");
   end

endmodule
